// File: rtl/led_pkg.sv
// Shared definitions for the LED flash driver: state encoding, default
// half-period lengths and counter sizing helpers.
package led_pkg;

  localparam int unsigned HALF_SLOW_DEF = 12_500_000;
  localparam int unsigned HALF_FAST_DEF = 2_500_000;
  localparam int unsigned TIMES_W       = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ON       = 3'd1,
    OFF      = 3'd2,
    DONE     = 3'd3,
    WAIT_REL = 3'd4
  } led_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter running 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the value n itself.
  function automatic int unsigned len_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flash_tick_gen.sv
// Phase counter: counts 0..half_len-1 while run is high and flags the
// terminal count on tick, wrapping back to zero on that same edge.
module flash_tick_gen #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [LEN_W-1:0] half_len,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  assign term = CNT_W'(half_len - LEN_W'(1));
  assign tick = run && (cnt == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_flash_drv.sv
// Blinks an LED a latched number of times at a latched rate, then pulses
// flash_done and waits for the request to be released.
module led_flash_drv
  import led_pkg::*;
#(
  parameter int unsigned HALF_SLOW = HALF_SLOW_DEF,
  parameter int unsigned HALF_FAST = HALF_FAST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [TIMES_W-1:0] times,
  output logic               led,
  output logic               flash_done,
  output logic               busy
);

  localparam int unsigned HALF_MAX = max_u(HALF_SLOW, HALF_FAST);
  localparam int unsigned CNT_W    = cnt_width(HALF_MAX);
  localparam int unsigned LEN_W    = len_width(HALF_MAX);

  led_state_t         state;
  logic [TIMES_W-1:0] tgt;
  logic [TIMES_W-1:0] flash_cnt;
  logic [TIMES_W-1:0] flash_cnt_inc;
  logic               mode_q;
  logic [LEN_W-1:0]   half_len;
  logic               tick;
  logic               run;
  logic               clr;

  assign half_len      = mode_q ? LEN_W'(HALF_FAST) : LEN_W'(HALF_SLOW);
  assign run           = (state == ON) || (state == OFF);
  assign clr           = !run;
  assign flash_cnt_inc = flash_cnt + TIMES_W'(1);

  flash_tick_gen #(
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .run      (run),
    .half_len (half_len),
    .tick     (tick)
  );

  // Outputs are driven for the state being entered, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      led        <= 1'b0;
      flash_done <= 1'b0;
      busy       <= 1'b0;
      flash_cnt  <= '0;
      tgt        <= '0;
      mode_q     <= 1'b0;
    end else begin
      led        <= 1'b0;
      flash_done <= 1'b0;
      busy       <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            tgt       <= times;
            mode_q    <= mode;
            flash_cnt <= '0;
            busy      <= 1'b1;
            if (times != '0) begin
              state <= ON;
              led   <= 1'b1;
            end else begin
              state      <= DONE;
              flash_done <= 1'b1;
            end
          end
        end
        ON: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            state <= OFF;
            busy  <= 1'b1;
          end else begin
            led  <= 1'b1;
            busy <= 1'b1;
          end
        end
        OFF: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            busy <= 1'b1;
            if (tick) begin
              flash_cnt <= flash_cnt_inc;
              if (flash_cnt_inc == tgt) begin
                state      <= DONE;
                flash_done <= 1'b1;
              end else begin
                state <= ON;
                led   <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!en) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_flash_drv.sv
// Bench for led_flash_drv with short half-periods: fixed vector table,
// directed corner sequences and randomized traffic against a timeline model.
module tb_led_flash_drv;

  localparam int unsigned HS = 4;
  localparam int unsigned HF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [5:0] times;
  logic       led;
  logic       flash_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  led_flash_drv #(
    .HALF_SLOW (HS),
    .HALF_FAST (HF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .times      (times),
    .led        (led),
    .flash_done (flash_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a sequence is a timeline of 2*H*n cycles measured from
  // its start; led is high in the first half of every 2*H window.
  typedef enum {M_IDLE, M_RUN, M_DONE, M_HOLD} mphase_t;
  mphase_t mp = M_IDLE;
  int      m_e = 0;
  int      m_h = 0;
  int      m_n = 0;
  logic    exp_led;
  logic    exp_busy;
  logic    exp_done;

  task automatic model_update();
    if (rst) begin
      mp = M_IDLE;
    end else begin
      case (mp)
        M_IDLE: if (en) begin
          m_h = mode ? HF : HS;
          m_n = int'(times);
          m_e = 0;
          mp  = (m_n == 0) ? M_DONE : M_RUN;
        end
        M_RUN: if (!en) mp = M_IDLE;
               else begin
                 m_e++;
                 if (m_e == 2 * m_h * m_n) mp = M_DONE;
               end
        M_DONE: mp = M_HOLD;
        M_HOLD: if (!en) mp = M_IDLE;
        default: mp = M_IDLE;
      endcase
    end
    exp_led  = (mp == M_RUN) && (((m_e / m_h) % 2) == 0);
    exp_busy = (mp == M_RUN) || (mp == M_DONE);
    exp_done = (mp == M_DONE);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare all outputs against it shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model_led", int'(led), int'(exp_led));
    chk("model_busy", int'(busy), int'(exp_busy));
    chk("model_done", int'(flash_done), int'(exp_done));
  endtask

  // Start a sequence and measure when flash_done fires and how many flashes occur.
  task automatic run_seq(input logic m, input logic [5:0] n, input bit scramble,
                         input int exp_done_at, input int exp_rises);
    int   done_at;
    int   rises;
    logic prev_led;
    done_at  = -1;
    rises    = 0;
    prev_led = 1'b0;
    mode  = m;
    times = n;
    en    = 1'b1;
    for (int i = 1; i <= 300 && done_at < 0; i++) begin
      step();
      if (i == 1) chk("first_led", int'(led), (n != 0) ? 1 : 0);
      if (led && !prev_led) rises++;
      prev_led = led;
      if (flash_done) done_at = i;
      if (scramble) begin
        mode  = 1'($urandom);
        times = 6'($urandom);
      end
    end
    chk("done_latency", done_at, exp_done_at);
    chk("led_rises", rises, exp_rises);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_after_done", int'(busy), 0);
      chk("no_restart_led", int'(led), 0);
    end
    en = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic [5:0] times;
    logic       led;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[12];

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    times = 6'd0;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 6'd7, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 6'd7, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst   = vt[i].rst;
      en    = vt[i].en;
      mode  = vt[i].mode;
      times = vt[i].times;
      step();
      chk($sformatf("vec%0d_led", i), int'(led), int'(vt[i].led));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy));
      chk($sformatf("vec%0d_done", i), int'(flash_done), int'(vt[i].done));
    end

    // Slow and fast blink: done at 2*H*times+1 cycles after the start edge.
    run_seq(1'b0, 6'd3, 1'b0, 2 * HS * 3 + 1, 3);
    run_seq(1'b1, 6'd5, 1'b0, 2 * HF * 5 + 1, 5);
    run_seq(1'b0, 6'd0, 1'b0, 1, 0);
    // Inputs scrambled after the latch must not change the sequence.
    run_seq(1'b0, 6'd2, 1'b1, 2 * HS * 2 + 1, 2);

    // Abort during the second OFF phase.
    mode  = 1'b0;
    times = 6'd3;
    en    = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("abort_pre_led", int'(led), 0);
    chk("abort_pre_busy", int'(busy), 1);
    en = 1'b0;
    step();
    chk("abort_led", int'(led), 0);
    chk("abort_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", int'(flash_done), 0);
    end

    // Reset in the middle of an ON phase with the request still held.
    times = 6'd2;
    en    = 1'b1;
    step();
    step();
    chk("pre_rst_led", int'(led), 1);
    rst = 1'b1;
    step();
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(flash_done), 0);
    rst = 1'b0;
    step();
    chk("restart_led", int'(led), 1);
    chk("restart_busy", int'(busy), 1);
    en = 1'b0;
    step();
    step();

    // Randomized traffic; en toggles rarely so most sequences complete.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) en = ~en;
      rst   = ($urandom_range(0, 299) == 0);
      mode  = 1'($urandom);
      times = 6'($urandom_range(0, 4));
      step();
    end
    rst = 1'b0;
    en  = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_flash_drv.md
LED_FLASH_DRV -- requirements
Module: led_flash_drv

Interface
REQ-001 SHALL have parameter HALF_SLOW, default 12_500_000, giving the clk cycles per LED half-period in mode 0 (0.25 s at 50 MHz).
REQ-002 SHALL have parameter HALF_FAST, default 2_500_000, giving the clk cycles per LED half-period in mode 1; both parameters are at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: flash request from the key-duration FSM, held high until flash_done is seen.
REQ-006 SHALL have port mode, input, 1 bit: 0 selects the slow blink, 1 selects the fast blink.
REQ-007 SHALL have port times, input, 6 bits: number of flashes to produce, range 0..63.
REQ-008 SHALL have port led, output, 1 bit: LED drive, active high.
REQ-009 SHALL have port flash_done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1 bit: high while a flash sequence is in progress.

Function
REQ-011 SHALL implement an FSM with the states IDLE, ON, OFF, DONE and WAIT_REL.
REQ-012 IDLE, en=1: SHALL latch times into tgt and mode into mode_q; SHALL clear flash_cnt and the phase counter; SHALL go to ON if times≠0, otherwise to DONE.
REQ-013 SHALL ignore changes on mode and times after the latch until the FSM returns to IDLE.
REQ-014 ON: the phase counter SHALL count 0..H-1, where H = HALF_FAST if mode_q=1, else HALF_SLOW; at H-1 it SHALL clear and the FSM SHALL go to OFF.
REQ-015 OFF: the phase counter SHALL count 0..H-1; at H-1 it SHALL clear and flash_cnt SHALL increment; if flash_cnt+1 = tgt the FSM SHALL go to DONE, otherwise to ON.
REQ-016 DONE: flash_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_REL.
REQ-017 WAIT_REL: the FSM SHALL go to IDLE when en=0; while en stays 1 it SHALL remain in WAIT_REL and SHALL NOT restart.
REQ-018 All outputs SHALL be registered.
REQ-019 led SHALL be 1 exactly in the cycles the FSM is in ON.
REQ-020 busy SHALL be 1 in ON, OFF and DONE.
REQ-021 Latency: if en is first sampled high at cycle k, led SHALL rise at k+1 and flash_done SHALL be high at k+2·H·times+1; for times=0, flash_done SHALL be high at k+1.
REQ-022 Abort: en=0 while in ON or OFF SHALL return the FSM to IDLE on the next edge, with led=0, busy=0 and no flash_done pulse.
REQ-023 The phase counter SHALL be sized by $clog2(max(HALF_SLOW,HALF_FAST)) and flash_cnt SHALL be 6 bits; neither SHALL wrap within a legal sequence.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, led=0, flash_done=0, busy=0, flash_cnt=0, phase counter=0, tgt=0 and mode_q=0, including mid-sequence.
REQ-025 After rst is released, a pending en=1 SHALL start a new sequence on the first edge with rst=0.

Structure
REQ-026 The state encoding and the default HALF_SLOW/HALF_FAST values SHALL live in a shared package, led_pkg.
REQ-027 The phase counter SHALL be one sub-module, flash_tick_gen, with inputs clr and half_len and output tick, asserted on the terminal count.

Verification (HALF_SLOW=4, HALF_FAST=2)
REQ-028 en=1 at k, mode=0, times=3 -> led 1 for 4 cycles and 0 for 4 cycles, three times; flash_done pulse at k+25; busy low after it.
REQ-029 en=1, mode=1, times=5 -> led period of 4 cycles; exactly 5 rising edges; flash_done at k+21.
REQ-030 times=0, en=1 -> led stays 0; flash_done at k+1; no restart while en is held high.
REQ-031 Sequence running; en dropped in the 2nd OFF phase -> led=0 and busy=0 next cycle; no flash_done pulse.
REQ-032 rst=1 for one cycle in the middle of an ON phase -> all outputs 0 next cycle; en still high -> new sequence, led rises 1 cycle after rst falls.
REQ-033 mode and times toggled mid-sequence -> flash count and period unchanged from the latched values.
